// File: rtl/iddr_pkg.sv
// Shared constants and elaboration helpers for the iddr_deser block.
package iddr_pkg;

    localparam logic [23:0] DR_DDR = "DDR";
    localparam logic [23:0] DR_SDR = "SDR";

    // Posedges needed to collect one RATIO-bit word.
    function automatic int unsigned cpw(input int unsigned ratio, input logic [23:0] rate);
        return (rate == DR_DDR) ? ratio / 2 : ratio;
    endfunction

    // History depth: one full word plus RATIO-1 older bits for the slip window.
    function automatic int unsigned hist_w(input int unsigned ratio);
        return 2 * ratio - 1;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic params_legal(input int unsigned width, input int unsigned ratio,
                                          input logic [23:0] rate);
        if (width < 1 || width > 32) return 1'b0;
        if (ratio < 2 || ratio > 16) return 1'b0;
        if (rate == DR_DDR) return (ratio % 2) == 0;
        return rate == DR_SDR;
    endfunction

endpackage

// File: rtl/iddr_deser_lane.sv
// One lane: edge capture flops, history shift register and slip-selected window.
module iddr_deser_lane
    import iddr_pkg::*;
#(
    parameter int unsigned RATIO     = 4,
    parameter logic [23:0] DATA_RATE = DR_DDR,
    parameter logic        INIT_Q    = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_ce,
    input  logic                       i_d,
    input  logic                       i_shift,
    input  logic [$clog2(RATIO)-1:0]   i_slip,
    output logic [RATIO-1:0]           o_window
);

    localparam int unsigned HW  = hist_w(RATIO);
    localparam int unsigned HIW = $clog2(HW);

    logic          r_rise;
    logic [HW-1:0] r_hist;
    logic [HW-1:0] w_hist_next;
    logic [HIW-1:0] w_idx;

    // Rising-edge capture of the serial input.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)  r_rise <= INIT_Q;
        else if (i_ce) r_rise <= i_d;
    end

    if (DATA_RATE == DR_DDR) begin : g_ddr
        logic r_fall;

        // Falling-edge capture; reset is sampled on this edge as well.
        always_ff @(negedge i_clk) begin
            if (!i_rst_n)  r_fall <= INIT_Q;
            else if (i_ce) r_fall <= i_d;
        end

        // Rise bit is older than fall bit; truncation drops the oldest two bits.
        assign w_hist_next = HW'({r_hist, r_rise, r_fall});
    end else begin : g_sdr
        assign w_hist_next = HW'({r_hist, r_rise});
    end

    // History register, newest bit at index 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)     r_hist <= '0;
        else if (i_shift) r_hist <= w_hist_next;
    end

    // Window taken from the post-shift history so an emit sees the completing bits.
    assign w_idx    = HIW'(i_slip);
    assign o_window = w_hist_next[w_idx +: RATIO];

endmodule

// File: rtl/iddr_deser.sv
// Multi-lane IDDR deserialiser with shared word framing and bitslip.
module iddr_deser
    import iddr_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned RATIO     = 4,
    parameter logic [23:0] DATA_RATE = DR_DDR,
    parameter logic        INIT_Q    = 1'b0
) (
    input  logic                       C,
    input  logic                       R,
    input  logic                       CE,
    input  logic [WIDTH-1:0]           D,
    input  logic                       BITSLIP,
    output logic [WIDTH*RATIO-1:0]     Q,
    output logic                       Q_VALID,
    output logic [$clog2(RATIO)-1:0]   SLIP_OFS
);

    localparam int unsigned CPW = cpw(RATIO, DATA_RATE);
    localparam int unsigned CW  = cnt_w(CPW);
    localparam int unsigned OW  = $clog2(RATIO);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPW - 1);
    localparam logic [OW-1:0] OFS_LAST = OW'(RATIO - 1);

    if (!params_legal(WIDTH, RATIO, DATA_RATE)) begin : g_bad_params
        $error("iddr_deser: illegal WIDTH/RATIO/DATA_RATE combination");
    end

    logic                   r_prime;
    logic [CW-1:0]          r_cnt;
    logic [OW-1:0]          r_ofs;
    logic [WIDTH*RATIO-1:0] r_q;
    logic                   r_qv;
    logic                   w_shift;
    logic                   w_emit;
    logic [WIDTH*RATIO-1:0] w_words;

    assign w_shift = CE & r_prime;
    assign w_emit  = w_shift && (r_cnt == CNT_LAST);

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        iddr_deser_lane #(
            .RATIO     (RATIO),
            .DATA_RATE (DATA_RATE),
            .INIT_Q    (INIT_Q)
        ) u_lane (
            .i_clk    (C),
            .i_rst_n  (R),
            .i_ce     (CE),
            .i_d      (D[g]),
            .i_shift  (w_shift),
            .i_slip   (r_ofs),
            .o_window (w_words[g*RATIO +: RATIO])
        );
    end

    // Shared framing: prime, word counter, slip offset and output word register.
    always_ff @(posedge C) begin
        if (!R) begin
            r_prime <= 1'b0;
            r_cnt   <= '0;
            r_ofs   <= '0;
            r_q     <= {(WIDTH*RATIO){INIT_Q}};
            r_qv    <= 1'b0;
        end else begin
            r_qv <= 1'b0;
            if (CE) begin
                if (!r_prime) begin
                    r_prime <= 1'b1;
                end else begin
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                    if (BITSLIP) r_ofs <= (r_ofs == OFS_LAST) ? '0 : r_ofs + 1'b1;
                    if (w_emit) begin
                        r_q  <= w_words;
                        r_qv <= 1'b1;
                    end
                end
            end
        end
    end

    assign Q        = r_q;
    assign Q_VALID  = r_qv;
    assign SLIP_OFS = r_ofs;

endmodule
